// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory macro.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  // requester side, packed {requester1, requester0}
  logic [1:0]      req;
  logic [1:0]      we;
  logic [3:0]      mode;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [1:0]      gnt;
  logic [1:0]      rvalid;
  logic [DW-1:0]   rdata;

  // memory side
  logic            mem_en;
  logic            mem_we;
  logic [1:0]      mem_mode;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  // status
  logic            busy;
  logic            owner;

  // environment view: requesters plus the memory macro
  modport master (
    output req, we, mode, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_we, mem_mode, mem_addr, mem_wdata,
           busy, owner
  );

  // arbiter view
  modport slave (
    input  req, we, mode, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_mode, mem_addr, mem_wdata,
           busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between the core
// (requester 0) and the debug/loader port (requester 1).
// Each transaction runs ARB -> ISSUE -> RESP; arbitration for the next one
// overlaps the RESP cycle so back-to-back traffic sustains one access per
// two cycles.
module mem_port_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Captured access, frozen at the arbitration edge.
  typedef struct packed {
    logic          we;
    logic [1:0]    mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } xact_t;

  state_t     state;
  logic       last;
  logic       owner_q;
  logic [1:0] gnt_q;
  logic [1:0] rvalid_q;
  logic       mem_en_q;
  logic       mem_we_q;
  logic       busy_q;
  xact_t      cap;

  logic       any_req;
  logic       win;
  xact_t      sel;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Pick the winner (tie goes to the requester that did not win last) and
  // mux out its request fields.
  always_comb begin
    any_req = |bus.req;
    win     = 1'b0;
    if (bus.req == 2'b11) begin
      win = ~last;
    end else if (bus.req[1]) begin
      win = 1'b1;
    end
    sel.we    = win ? bus.we[1]          : bus.we[0];
    sel.mode  = win ? bus.mode[3:2]      : bus.mode[1:0];
    sel.addr  = win ? bus.addr[AW +: AW] : bus.addr[0 +: AW];
    sel.wdata = win ? bus.wdata[DW +: DW] : bus.wdata[0 +: DW];
  end

  // Transaction sequencer; strobes default low so gnt/rvalid/mem_en are
  // single-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner_q  <= 1'b0;
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      busy_q   <= 1'b0;
      cap      <= '0;
    end else begin
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      unique case (state)
        IDLE, RESP: begin
          if (any_req) begin
            state    <= ISSUE;
            cap      <= sel;
            owner_q  <= win;
            last     <= win;
            gnt_q    <= onehot(win);
            mem_en_q <= 1'b1;
            mem_we_q <= sel.we;
            busy_q   <= 1'b1;
          end else begin
            state    <= IDLE;
            busy_q   <= 1'b0;
          end
        end
        ISSUE: begin
          state    <= RESP;
          rvalid_q <= onehot(owner_q);
          busy_q   <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  // Memory read data lands in the RESP cycle, so it is forwarded straight
  // through; writes return zero with their completion ack.
  assign bus.rdata = ((|rvalid_q) && !cap.we) ? bus.mem_rdata : DW'(0);

  // Output drive from registered state.
  assign bus.gnt       = gnt_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_mode  = cap.mode;
  assign bus.mem_addr  = cap.addr;
  assign bus.mem_wdata = cap.wdata;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory macro and a
// response scoreboard.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [1:0]  rv;
    logic [31:0] rd;
  } sb_item_t;

  sb_item_t    sb[$];
  sb_item_t    mon_e;
  logic [31:0] mem[logic [31:0]];

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  // Memory macro: one-cycle synchronous read, write on the strobe edge.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      else            bus.mem_rdata <= mem_rd(bus.mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] rv, input logic [31:0] rd);
    sb_item_t it;
    it.rv = rv;
    it.rd = rd;
    sb.push_back(it);
  endtask

  // Response monitor: every rvalid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.rvalid !== 2'b00) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_unexpected observed rvalid=%b expected none", bus.rvalid);
      end else begin
        mon_e = sb.pop_front();
        chk("rvalid", 64'(bus.rvalid), 64'(mon_e.rv));
        chk("rdata", 64'(bus.rdata), 64'(mon_e.rd));
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.req       = 2'b00;
    bus.we        = 2'b00;
    bus.mode      = 4'b0000;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.mem_rdata = '0;
    mem[32'h100]  = 32'hDEADBEEF;

    // reset values
    #3;
    chk("rst_gnt",    64'(bus.gnt), 64'd0);
    chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
    chk("rst_rdata",  64'(bus.rdata), 64'd0);
    chk("rst_mem",    64'({bus.mem_en, bus.mem_we, bus.mem_mode}), 64'd0);
    chk("rst_addr",   64'(bus.mem_addr), 64'd0);
    chk("rst_wdata",  64'(bus.mem_wdata), 64'd0);
    chk("rst_status", 64'({bus.busy, bus.owner}), 64'd0);
    tick();
    tick();
    reset = 1'b0;

    // single read, requester 0
    bus.req  = 2'b01;
    bus.addr = {32'h0, 32'h100};
    tick();
    chk("rd_gnt",    64'(bus.gnt), 64'h1);
    chk("rd_en_we",  64'({bus.mem_en, bus.mem_we}), 64'b10);
    chk("rd_addr",   64'(bus.mem_addr), 64'h100);
    chk("rd_busy",   64'({bus.busy, bus.owner}), 64'b10);
    push(2'b01, 32'hDEADBEEF);
    tick();
    bus.req = 2'b00;
    chk("rd_resp_en", 64'({bus.mem_en, bus.gnt}), 64'd0);
    chk("rd_resp_busy", 64'(bus.busy), 64'd1);
    tick();
    chk("rd_idle", 64'({bus.busy, bus.rvalid}), 64'd0);

    // single write, requester 1, byte mode
    bus.req   = 2'b10;
    bus.we    = 2'b10;
    bus.mode  = 4'b1000;
    bus.addr  = {32'h20, 32'h0};
    bus.wdata = {32'hAB, 32'h0};
    tick();
    chk("wr_we",    64'(bus.mem_we), 64'd1);
    chk("wr_mode",  64'(bus.mem_mode), 64'b10);
    chk("wr_addr",  64'(bus.mem_addr), 64'h20);
    chk("wr_wdata", 64'(bus.mem_wdata), 64'hAB);
    chk("wr_gnt",   64'(bus.gnt), 64'b10);
    chk("wr_owner", 64'(bus.owner), 64'd1);
    push(2'b10, 32'h0);
    tick();
    bus.req  = 2'b00;
    bus.we   = 2'b00;
    bus.mode = 4'b0000;
    chk("wr_resp_we", 64'({bus.mem_en, bus.mem_we}), 64'd0);
    tick();

    // reset pulse so the tie starts from the reset pointer
    reset = 1'b1;
    #1;
    chk("rst2_owner", 64'(bus.owner), 64'd0);
    tick();
    reset = 1'b0;

    // tie held continuously: grants alternate starting with requester 0
    bus.req  = 2'b11;
    bus.addr = {32'h100, 32'h20};
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tie_gnt",   64'(bus.gnt), (k % 2 == 0) ? 64'b01 : 64'b10);
      chk("tie_owner", 64'(bus.owner), (k % 2 == 0) ? 64'd0 : 64'd1);
      push((k % 2 == 0) ? 2'b01 : 2'b10, (k % 2 == 0) ? mem_rd(32'h20) : 32'hDEADBEEF);
      tick();
      if (k == 3) bus.req = 2'b00;
      chk("tie_space", 64'({bus.gnt, bus.mem_en}), 64'd0);
    end
    tick();
    chk("tie_idle", 64'(bus.busy), 64'd0);

    // capture isolation and back-to-back from the same requester
    bus.req  = 2'b01;
    bus.addr = {32'h0, 32'h100};
    tick();
    chk("b2b_gnt0", 64'(bus.gnt), 64'b01);
    push(2'b01, 32'hDEADBEEF);
    bus.addr = {32'h0, 32'h200};
    #1;
    chk("cap_addr", 64'(bus.mem_addr), 64'h100);
    tick();
    bus.addr = {32'h0, 32'h104};
    chk("cap_addr_resp", 64'(bus.mem_addr), 64'h100);
    tick();
    chk("b2b_gnt1", 64'(bus.gnt), 64'b01);
    chk("b2b_en",   64'({bus.mem_en, bus.busy}), 64'b11);
    chk("b2b_addr", 64'(bus.mem_addr), 64'h104);
    push(2'b01, mem_rd(32'h104));
    tick();
    bus.req = 2'b00;
    tick();
    chk("b2b_idle", 64'(bus.busy), 64'd0);

    // reset during the ISSUE cycle of a write
    bus.req   = 2'b10;
    bus.we    = 2'b10;
    bus.addr  = {32'h40, 32'h0};
    bus.wdata = {32'h55, 32'h0};
    tick();
    chk("mr_we_pre", 64'(bus.mem_we), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_we",   64'({bus.mem_en, bus.mem_we}), 64'd0);
    chk("mr_gnt",  64'(bus.gnt), 64'd0);
    chk("mr_busy", 64'(bus.busy), 64'd0);
    bus.req  = 2'b11;
    bus.we   = 2'b00;
    bus.addr = {32'h40, 32'h300};
    tick();
    tick();
    reset = 1'b0;
    chk("mr_nowrite", 64'(mem.exists(32'h40)), 64'd0);
    tick();
    chk("mr_gnt_after", 64'(bus.gnt), 64'b01);
    chk("mr_owner",     64'(bus.owner), 64'd0);
    push(2'b01, mem_rd(32'h300));
    tick();
    bus.req = 2'b00;
    tick();
    chk("end_idle", 64'(bus.busy), 64'd0);
    tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port between two requesters: requester 0 (the multicycle core's fetch/load/store path) and requester 1 (the debug/program-loader port). Arbitration is round-robin, with a registered three-phase transaction sequence (ARB, ISSUE, RESP). Sits between the requesters and the memory macro; memory has 1-cycle synchronous read latency.

Parameters:
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  2  per-requester request, bit i = requester i
we  in  2  per-requester write enable (1 = store)
mode  in  4  per-requester access size {mode1,mode0}; 00 word, 01 half, 10 byte, 11 reserved
addr  in  2*AW  per-requester address {addr1,addr0}
wdata  in  2*DW  per-requester write data {wdata1,wdata0}
gnt  out  2  one-hot accept pulse
rvalid  out  2  one-hot response pulse
rdata  out  DW  read data, shared, qualified by rvalid
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_mode  out  2  access size to memory
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid the cycle after mem_en
busy  out  1  transaction in flight
owner  out  1  index of current/last granted requester

Behaviour:
- States: IDLE, ISSUE, RESP. Reset -> IDLE. Outputs at reset: gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_mode=0, mem_addr=0, mem_wdata=0, busy=0, owner=0.
- Round-robin pointer last (1 bit); reset value 1, so requester 0 wins the first tie.
- Arbitration runs in IDLE, and in RESP when any req is high:
  - Single req: that requester wins.
  - Both: winner = ~last.
  - On win: capture the winner's we/mode/addr/wdata into registers; owner <= winner; last <= winner; next state ISSUE.
- ISSUE, one cycle:
  - mem_en=1; mem_we=captured we; mem_mode/mem_addr/mem_wdata = captured values.
  - gnt[owner]=1. busy=1.
  - Next state RESP.
- RESP, one cycle:
  - rvalid[owner]=1; rdata = mem_rdata for reads; rdata = 0 for writes. rvalid also pulses for writes, as the completion ack.
  - mem_en=0, mem_we=0. busy=1.
  - Next state ISSUE if any req is high (back-to-back arbitration), else IDLE.
- Latency:
  - From IDLE: req sampled at edge N -> gnt during cycle N+1 -> rvalid/rdata during cycle N+2.
  - Sustained throughput: one transaction per 2 cycles.
- Requester rules:
  - Hold req, we, mode, addr, wdata stable until gnt is seen.
  - Deassert req in the cycle after gnt unless issuing a new transaction. A req still high in RESP is a new request.
  - Fields are captured at the ARB edge, so later input changes do not affect an in-flight access.
- mode=11 is passed through unchanged; memory treats it as word. The arbiter does not check alignment.
- mem_we is high only in ISSUE; it is never high in IDLE or RESP.
- Simultaneous requests in RESP: the pointer update from the just-finished owner applies, so the other requester wins. Alternation is guaranteed; no starvation (worst case 1 intervening transaction).
- Reset mid-transaction (any state):
  - Outputs go to reset values immediately (asynchronous); mem_we drops in the same cycle.
  - The in-flight transaction is abandoned; no rvalid is issued.
  - last <= 1.
- Widths: no arithmetic. All buses pass through at DW/AW; the packed slice for requester i is [i*W +: W].

Test Plan:
- Single read: after reset, req=01, we=00, addr0=0x100, mem_rdata=0xDEADBEEF -> gnt=01 in cycle 2, mem_en=1, mem_addr=0x100, mem_we=0; cycle 3: rvalid=01, rdata=0xDEADBEEF; then IDLE, busy=0.
- Single write, requester 1: req=10, we=10, mode1=10, addr1=0x20, wdata1=0xAB -> ISSUE: mem_we=1, mem_mode=10, mem_addr=0x20, mem_wdata=0xAB, gnt=10; RESP: rvalid=10, rdata=0, mem_we=0.
- Tie after reset: req=11 held continuously -> grants alternate 01,10,01,10 on every ISSUE cycle (2-cycle spacing); owner toggles.
- Back-to-back same requester: req0 re-asserted in the RESP cycle with addr0=0x104 -> next cycle is ISSUE with mem_addr=0x104; no IDLE cycle in between.
- Input change after capture: addr0 changed from 0x100 to 0x200 during ISSUE -> mem_addr stays 0x100 for that access.
- Reset during ISSUE of a write: reset asserted mid-cycle -> mem_we, mem_en, gnt fall immediately; no rvalid; after release with req=11, requester 0 is granted first.
